// File: rtl/pipelined_inst_decoder.sv
// Registered decode stage for a MIPS subset: valid/ready on both sides, load-use
// bubble insertion, halt/resume, flush and a saturating stall-cycle counter.
module pipelined_inst_decoder #(
    parameter int unsigned IMM_W          = 32,
    parameter int unsigned REG_ADDR_W     = 5,
    parameter int unsigned LOAD_USE_STALL = 1,
    parameter int unsigned STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   resume,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_reg_write,
    output logic                   out_reg_dst,
    output logic                   out_alu_src2,
    output logic [2:0]             out_alu_op,
    output logic                   out_mem_read,
    output logic                   out_mem_write,
    output logic                   out_mem_to_reg,
    output logic [REG_ADDR_W-1:0]  out_rs,
    output logic [REG_ADDR_W-1:0]  out_rt,
    output logic [REG_ADDR_W-1:0]  out_wr_addr,
    output logic [IMM_W-1:0]       out_imm,
    output logic                   out_branch,
    output logic                   out_jump,
    output logic                   out_halt,
    output logic                   out_illegal,
    output logic [25:0]            out_jump_target,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int unsigned CNT_W = (LOAD_USE_STALL < 2) ? 1 : $clog2(LOAD_USE_STALL + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic [1:0] {RUN, STALL, HALT} state_e;

    typedef struct packed {
        logic                  reg_write;
        logic                  reg_dst;
        logic                  alu_src2;
        logic [2:0]            alu_op;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] wr_addr;
        logic [IMM_W-1:0]      imm;
        logic                  branch;
        logic                  jump;
        logic                  halt;
        logic                  illegal;
        logic [25:0]           jump_target;
    } bundle_t;

    state_e                state;
    logic [CNT_W-1:0]      stall_cnt;
    logic                  ld_pending;
    logic [REG_ADDR_W-1:0] ld_rt;
    bundle_t               bundle_q;
    bundle_t               dec_c;
    logic                  reads_rt_c;
    logic                  hazard_c;
    logic                  accept_c;

    logic [5:0]            opcode_c;
    logic [5:0]            funct_c;
    logic [REG_ADDR_W-1:0] rs_c;
    logic [REG_ADDR_W-1:0] rt_c;
    logic [REG_ADDR_W-1:0] rd_c;

    assign opcode_c = in_instr[31:26];
    assign funct_c  = in_instr[5:0];
    assign rs_c     = REG_ADDR_W'(in_instr[25:21]);
    assign rt_c     = REG_ADDR_W'(in_instr[20:16]);
    assign rd_c     = REG_ADDR_W'(in_instr[15:11]);

    // Instruction decode into the control bundle
    always_comb begin
        dec_c             = '0;
        dec_c.rs          = rs_c;
        dec_c.rt          = rt_c;
        dec_c.imm         = IMM_W'($signed(in_instr[15:0]));
        dec_c.jump_target = in_instr[25:0];
        unique case (opcode_c)
            OP_RTYPE: begin
                dec_c.reg_dst   = 1'b1;
                dec_c.wr_addr   = rd_c;
                dec_c.reg_write = 1'b1;
                unique case (funct_c)
                    6'h20:   dec_c.alu_op = 3'b000;
                    6'h22:   dec_c.alu_op = 3'b010;
                    6'h2A:   dec_c.alu_op = 3'b100;
                    default: begin
                        dec_c.illegal   = 1'b1;
                        dec_c.reg_dst   = 1'b0;
                        dec_c.wr_addr   = '0;
                        dec_c.reg_write = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                dec_c.alu_src2   = 1'b1;
                dec_c.mem_read   = 1'b1;
                dec_c.mem_to_reg = 1'b1;
                dec_c.wr_addr    = rt_c;
                dec_c.reg_write  = 1'b1;
            end
            OP_SW: begin
                dec_c.alu_src2  = 1'b1;
                dec_c.mem_write = 1'b1;
            end
            OP_ADDI: begin
                dec_c.alu_src2  = 1'b1;
                dec_c.wr_addr   = rt_c;
                dec_c.reg_write = 1'b1;
            end
            OP_BEQ: begin
                dec_c.branch = 1'b1;
                dec_c.alu_op = 3'b110;
            end
            OP_J:    dec_c.jump = 1'b1;
            OP_HALT: begin
                dec_c.halt   = 1'b1;
                dec_c.alu_op = 3'b001;
            end
            default: dec_c.illegal = 1'b1;
        endcase
    end

    // rs is treated as read by every instruction; rt only by R-type, beq and sw
    assign reads_rt_c = (opcode_c == OP_RTYPE) || (opcode_c == OP_BEQ) || (opcode_c == OP_SW);
    assign hazard_c   = (LOAD_USE_STALL != 0) && ld_pending && in_valid && (state == RUN) &&
                        ((rs_c == ld_rt) || (reads_rt_c && (rt_c == ld_rt)));

    assign in_ready = rst_n && (state == RUN) && !flush && !hazard_c && (!out_valid || out_ready);
    assign accept_c = in_valid && in_ready;
    assign halted   = (state == HALT);

    // Control FSM, hazard tracking and stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            stall_cnt   <= '0;
            ld_pending  <= 1'b0;
            ld_rt       <= '0;
            stall_count <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (flush) begin
                        ld_pending <= 1'b0;
                    end else if (hazard_c) begin
                        state     <= STALL;
                        stall_cnt <= CNT_W'(LOAD_USE_STALL);
                    end else if (accept_c) begin
                        ld_pending <= (opcode_c == OP_LW) && (rt_c != '0);
                        ld_rt      <= rt_c;
                        if (opcode_c == OP_HALT) state <= HALT;
                    end
                end
                STALL: begin
                    if (stall_count != '1) stall_count <= stall_count + STALL_CNT_W'(1);
                    stall_cnt <= stall_cnt - CNT_W'(1);
                    if (flush || stall_cnt <= CNT_W'(1)) begin
                        state      <= RUN;
                        ld_pending <= 1'b0;
                    end
                end
                HALT: begin
                    if (resume) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Output register: load on accept, drop on consume or flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            bundle_q  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept_c) begin
            out_valid <= 1'b1;
            bundle_q  <= dec_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_reg_write   = bundle_q.reg_write;
    assign out_reg_dst     = bundle_q.reg_dst;
    assign out_alu_src2    = bundle_q.alu_src2;
    assign out_alu_op      = bundle_q.alu_op;
    assign out_mem_read    = bundle_q.mem_read;
    assign out_mem_write   = bundle_q.mem_write;
    assign out_mem_to_reg  = bundle_q.mem_to_reg;
    assign out_rs          = bundle_q.rs;
    assign out_rt          = bundle_q.rt;
    assign out_wr_addr     = bundle_q.wr_addr;
    assign out_imm         = bundle_q.imm;
    assign out_branch      = bundle_q.branch;
    assign out_jump        = bundle_q.jump;
    assign out_halt        = bundle_q.halt;
    assign out_illegal     = bundle_q.illegal;
    assign out_jump_target = bundle_q.jump_target;

endmodule
